// File: rtl/alu_pkg.sv
// Shared constants for the RV32 ALU issue stage: ALU function codes,
// RV32I opcode / funct fields, and the sign bias used for signed compares.
package alu_pkg;

    // ALU function codes understood by the combinational execute-stage ALU
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;  // ALU computes B - A
    localparam logic [3:0] ALU_SLTU  = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;  // shifts B by A
    localparam logic [3:0] ALU_SRL   = 4'b0111;  // shifts B by A
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values: base encoding and the alternate (SUB / SRA / SRAI)
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // XOR both compare operands with this to turn unsigned less-than into signed
    localparam logic [31:0] SIGN_BIAS = 32'h8000_0000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decoder: instruction + PC + operand values become the
// ALU function code, the two operand buses, rd, write enable and illegal flag.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 4
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    output logic [FUNC_WIDTH-1:0] alu_ctrl,
    output logic [DATA_WIDTH-1:0] bus_a,
    output logic [DATA_WIDTH-1:0] bus_b,
    output logic [4:0]            rd,
    output logic                  we,
    output logic                  illegal
);

    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic                  reg_form;
    logic                  base_f7;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0] bias;
    logic [3:0]            ctrl;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  ill;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rd       = instr[11:7];
    assign reg_form = (opcode == OPC_OP);
    // Immediate forms carry imm bits in funct7, so only the register form checks it
    assign base_f7  = !reg_form || (funct7 == F7_BASE);
    assign imm_i    = DATA_WIDTH'($signed(instr[31:20]));
    assign imm_u    = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
    assign src2     = reg_form ? rs2_val : imm_i;
    assign shamt    = DATA_WIDTH'(reg_form ? rs2_val[4:0] : instr[24:20]);
    assign bias     = DATA_WIDTH'(SIGN_BIAS);

    // Opcode/funct decode into ALU code and operand routing; illegal forces a NOP-like ADD 0,0
    always_comb begin
        ctrl = ALU_ADD;
        op_a = '0;
        op_b = '0;
        ill  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (reg_form && funct7 == F7_ALT) begin
                            ctrl = ALU_SUB; op_a = rs2_val; op_b = rs1_val;
                        end else if (base_f7) begin
                            ctrl = ALU_ADD; op_a = rs1_val; op_b = src2;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    F3_SLL: begin
                        if (funct7 == F7_BASE) begin
                            ctrl = ALU_SLL; op_a = shamt; op_b = rs1_val;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    F3_SLT: begin
                        ctrl = ALU_SLTU; op_a = rs1_val ^ bias; op_b = src2 ^ bias;
                        ill  = !base_f7;
                    end
                    F3_SLTU: begin
                        ctrl = ALU_SLTU; op_a = rs1_val; op_b = src2; ill = !base_f7;
                    end
                    F3_XOR: begin
                        ctrl = ALU_XOR; op_a = rs1_val; op_b = src2; ill = !base_f7;
                    end
                    F3_OR: begin
                        ctrl = ALU_OR; op_a = rs1_val; op_b = src2; ill = !base_f7;
                    end
                    F3_AND: begin
                        ctrl = ALU_AND; op_a = rs1_val; op_b = src2; ill = !base_f7;
                    end
                    F3_SR: begin
                        if (funct7 == F7_BASE) begin
                            ctrl = ALU_SRL; op_a = shamt; op_b = rs1_val;
                        end else if (funct7 == F7_ALT) begin
                            ctrl = ALU_SRA; op_a = rs1_val; op_b = shamt;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                ctrl = ALU_PASSB; op_a = '0; op_b = imm_u;
            end
            OPC_AUIPC: begin
                ctrl = ALU_ADD; op_a = pc; op_b = imm_u;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ctrl = ALU_ADD;
            op_a = '0;
            op_b = '0;
        end
    end

    assign alu_ctrl = FUNC_WIDTH'(ctrl);
    assign bus_a    = op_a;
    assign bus_b    = op_b;
    assign illegal  = ill;
    assign we       = !ill && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the RV32 ALU: decodes accepted instructions
// and holds them in a 2-entry skid buffer (main drives the outputs, skid
// catches one entry while main is stalled) so in_ready comes from a flop.
//
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. The producer holds payload stable while valid & !ready; valid never
// depends combinationally on ready, and in_ready depends only on flops.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [DATA_WIDTH-1:0] in_rs2_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FUNC_WIDTH-1:0] out_alu_ctrl,
    output logic [DATA_WIDTH-1:0] out_bus_A,
    output logic [DATA_WIDTH-1:0] out_bus_B,
    output logic [4:0]            out_rd,
    output logic                  out_we,
    output logic                  out_illegal
);

    typedef struct packed {
        logic [FUNC_WIDTH-1:0] ctrl;
        logic [DATA_WIDTH-1:0] bus_a;
        logic [DATA_WIDTH-1:0] bus_b;
        logic [4:0]            rd;
        logic                  we;
        logic                  illegal;
    } entry_t;

    entry_t dec_entry;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   drain;

    alu_op_decode #(
        .DATA_WIDTH(DATA_WIDTH),
        .FUNC_WIDTH(FUNC_WIDTH)
    ) u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_val  (in_rs1_val),
        .rs2_val  (in_rs2_val),
        .alu_ctrl (dec_entry.ctrl),
        .bus_a    (dec_entry.bus_a),
        .bus_b    (dec_entry.bus_b),
        .rd       (dec_entry.rd),
        .we       (dec_entry.we),
        .illegal  (dec_entry.illegal)
    );

    assign accept = in_valid && !skid_valid_q;
    assign drain  = main_valid_q && out_ready;

    // Buffer next-state: flush wins; main refills from skid first so order is kept
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                // skid full implies in_ready was low, so no new entry this cycle
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    // Buffer registers; reset clears both entries and the presented payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready     = !skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_alu_ctrl = main_q.ctrl;
    assign out_bus_A    = main_q.bus_a;
    assign out_bus_B    = main_q.bus_b;
    assign out_rd       = main_q.rd;
    assign out_we       = main_q.we;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode vectors, backpressure, flush and
// asynchronous reset, then randomized traffic against a queue-based model.
module tb_alu_issue_stage;

  localparam int PW = 75;  // {ctrl4, A32, B32, rd5, we, illegal}

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_bus_A;
  logic [31:0] out_bus_B;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  int n_checks = 0;
  int n_errors = 0;

  logic [PW-1:0] exp_q[$];
  logic [31:0]   seen_q[$];
  bit            last_acc;

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1_val   (in_rs1_val),
    .in_rs2_val   (in_rs2_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_bus_A    (out_bus_A),
    .out_bus_B    (out_bus_B),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .out_illegal  (out_illegal)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode written from the RV32I instruction rules
  function automatic logic [PW-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] rs1, input logic [31:0] rs2);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] uimm;
    logic [31:0] src2;
    logic [31:0] shv;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    bit          ill;
    bit          regf;
    bit          f7ok;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    rd   = ins[11:7];
    imm  = {{20{ins[31]}}, ins[31:20]};
    uimm = {ins[31:12], 12'h000};
    regf = (opc == 7'h33);
    f7ok = !regf || (f7 == 7'h00);
    src2 = regf ? rs2 : imm;
    shv  = {27'd0, (regf ? rs2[4:0] : ins[24:20])};
    c = 4'd0; a = 32'd0; b = 32'd0; ill = 1'b0;
    if (opc == 7'h33 || opc == 7'h13) begin
      case (f3)
        3'd0: if (regf && f7 == 7'h20) {c, a, b} = {4'd1, rs2, rs1};
              else if (f7ok) {c, a, b} = {4'd0, rs1, src2};
              else ill = 1'b1;
        3'd1: if (f7 == 7'h00) {c, a, b} = {4'd6, shv, rs1}; else ill = 1'b1;
        3'd2: if (f7ok) {c, a, b} = {4'd2, rs1 + 32'h8000_0000, src2 + 32'h8000_0000}; else ill = 1'b1;
        3'd3: if (f7ok) {c, a, b} = {4'd2, rs1, src2}; else ill = 1'b1;
        3'd4: if (f7ok) {c, a, b} = {4'd5, rs1, src2}; else ill = 1'b1;
        3'd5: if (f7 == 7'h00) {c, a, b} = {4'd7, shv, rs1};
              else if (f7 == 7'h20) {c, a, b} = {4'd8, rs1, shv};
              else ill = 1'b1;
        3'd6: if (f7ok) {c, a, b} = {4'd4, rs1, src2}; else ill = 1'b1;
        default: if (f7ok) {c, a, b} = {4'd3, rs1, src2}; else ill = 1'b1;
      endcase
    end else if (opc == 7'h37) begin
      {c, a, b} = {4'd10, 32'd0, uimm};
    end else if (opc == 7'h17) begin
      {c, a, b} = {4'd0, pc, uimm};
    end else begin
      ill = 1'b1;
    end
    if (ill) {c, a, b} = '0;
    return {c, a, b, rd, (!ill && rd != 5'd0), ill};
  endfunction

  // Occupancy/order model: a FIFO of up to two decoded entries
  task automatic model_update();
    bit acc;
    bit drn;
    acc = rst_n && in_valid && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && out_ready;
    last_acc = acc && !flush;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_decode(in_instr, in_pc, in_rs1_val, in_rs2_val));
    end
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    if (exp_q.size() > 0)
      check("payload", {out_alu_ctrl, out_bus_A, out_bus_B, out_rd, out_we, out_illegal}, exp_q[0]);
  endtask

  // One clock: record the output transfer, advance model, check at negedge
  task automatic cycle();
    if (out_valid && out_ready && rst_n) seen_q.push_back(out_bus_B);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid   = 1'b1;
    in_instr   = ins;
    in_pc      = 32'h0000_1000;
    in_rs1_val = r1;
    in_rs2_val = r2;
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [3:0] ec, input logic [31:0] ea,
                       input logic [31:0] eb, input logic ewe, input logic eill);
    out_ready = 1'b1;
    offer(ins, r1, r2);
    cycle();
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_ctrl"}, out_alu_ctrl, ec);
    check({tag, "_A"}, out_bus_A, ea);
    check({tag, "_B"}, out_bus_B, eb);
    check({tag, "_we"}, out_we, ewe);
    check({tag, "_illegal"}, out_illegal, eill);
    cycle();
  endtask

  function automatic logic [31:0] addi_x5(input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, 5'd5, 7'h13};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    sel = $urandom_range(0, 9);
    w = $urandom;
    if (sel <= 3) begin
      w[6:0] = 7'h33;
      case ($urandom_range(0, 3))
        0, 1: w[31:25] = 7'h00;
        2: w[31:25] = 7'h20;
        default: ;
      endcase
    end else if (sel <= 6) begin
      w[6:0] = 7'h13;
      if ((w[14:12] == 3'd1 || w[14:12] == 3'd5) && $urandom_range(0, 3) != 0)
        w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    end else if (sel == 7) begin
      w[6:0] = 7'h37;
    end else if (sel == 8) begin
      w[6:0] = 7'h17;
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_payload", {out_alu_ctrl, out_bus_A, out_bus_B, out_rd, out_we, out_illegal}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // directed decode vectors
    issue("add", 32'h002081B3, 32'd5, 32'd7, 4'h0, 32'd5, 32'd7, 1'b1, 1'b0);
    check("add_rd", out_rd, 5'd3);
    issue("sub", 32'h402081B3, 32'd10, 32'd3, 4'h1, 32'd3, 32'd10, 1'b1, 1'b0);
    issue("slt", 32'h0020A1B3, 32'hFFFF_FFFF, 32'd1, 4'h2, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 1'b0);
    issue("slli", 32'h00409193, 32'd1, 32'd9, 4'h6, 32'd4, 32'd1, 1'b1, 1'b0);
    issue("illegal", 32'h0000007F, 32'h1234, 32'h5678, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    issue("lui_x0", 32'h12345037, 32'd1, 32'd2, 4'hA, 32'd0, 32'h1234_5000, 1'b0, 1'b0);
    issue("auipc", 32'h00001517, 32'd1, 32'd2, 4'h0, 32'h1000, 32'h1000, 1'b1, 1'b0);
    issue("sub_badf7", 32'h202081B3, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1);

    // backpressure: three back-to-back offers with the output stalled
    out_ready = 1'b0;
    seen_q.delete();
    offer(addi_x5(12'h011), 32'd0, 32'd0); cycle();
    offer(addi_x5(12'h022), 32'd0, 32'd0); cycle();
    offer(addi_x5(12'h033), 32'd0, 32'd0); cycle();
    check("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    check("bp_hold_B", out_bus_B, 32'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_acc) in_valid = 1'b0;
    end
    check("bp_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("bp_order0", seen_q[0], 32'h11);
      check("bp_order1", seen_q[1], 32'h22);
      check("bp_order2", seen_q[2], 32'h33);
    end

    // flush with both entries full and a new offer pending
    out_ready = 1'b0;
    offer(addi_x5(12'h011), 32'd0, 32'd0); cycle();
    offer(addi_x5(12'h022), 32'd0, 32'd0); cycle();
    offer(addi_x5(12'h044), 32'd0, 32'd0);
    flush = 1'b1;
    cycle();
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen_q.delete();
    for (int i = 0; i < 4; i++) cycle();
    check("fl_seen_cnt", seen_q.size(), 0);

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    offer(addi_x5(12'h055), 32'd0, 32'd0); cycle();
    offer(addi_x5(12'h066), 32'd0, 32'd0); cycle();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    cycle();
    rst_n = 1'b1;
    cycle();
    issue("post_rst_add", 32'h002081B3, 32'd20, 32'd22, 4'h0, 32'd20, 32'd22, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      flush      = ($urandom_range(0, 29) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_instr   = rand_instr();
      in_pc      = $urandom;
      in_rs1_val = $urandom;
      in_rs2_val = $urandom;
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
